// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready push into a FIFO, fractional baud
// generator, LSB-first serialiser with optional parity and 1 or 2 stop bits.
module uart_tx_buffered #(
    parameter int freq_in       = 1_000_000,
    parameter int freq_out      = 100_000,
    parameter int acc_precision = 16,
    parameter int data_bits     = 8,
    parameter int parity        = 0,
    parameter int stop_bits     = 1,
    parameter int fifo_depth    = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [data_bits-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          uart_out,
    output logic                          busy,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic [1:0]                    state_dbg
);

    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = $clog2(data_bits);
    localparam longint inc_l = ((longint'(freq_out) << (acc_precision - 4)) + (longint'(freq_in) >> 5))
                               / (longint'(freq_in) >> 4);
    localparam logic [acc_precision:0] increment = inc_l[acc_precision:0];
    localparam logic [ptr_w:0]         depth_c   = (ptr_w + 1)'(fifo_depth);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Handshake: a word is accepted on every posedge where data_valid && data_ready;
    // data_ready depends only on FIFO fullness and reset_n, never on data_valid.
    state_t                   state_q, state_d;
    logic [acc_precision:0]   acc_q, acc_d;
    logic                     uart_q, uart_d;
    logic [data_bits-1:0]     shift_q, shift_d;
    logic [cnt_w-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]               stop_cnt_q, stop_cnt_d;
    logic [ptr_w-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ptr_w:0]           count_q, count_d;
    logic [data_bits-1:0]     mem_q [fifo_depth];
    logic                     tick;
    logic                     push;
    logic                     pop;

    assign tick       = acc_q[acc_precision];
    assign data_ready = (count_q != depth_c) && reset_n;
    assign push       = data_valid && data_ready;
    assign uart_out   = uart_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign state_dbg  = state_q;

    always_comb begin
        state_d    = state_q;
        uart_d     = uart_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pop        = 1'b0;
        acc_d      = {1'b0, acc_q[acc_precision-1:0]} + increment;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        uart_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        uart_d = 1'b1;
                    end
                end
                DATA: begin
                    uart_d = shift_q[bit_cnt_q];
                    if (bit_cnt_q == cnt_w'(data_bits - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (parity != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    uart_d  = (parity == 2) ? ^shift_q : ~^shift_q;
                    state_d = STOP;
                end
                default: begin
                    uart_d = 1'b1;
                    if (stop_cnt_q == 2'(stop_bits - 1)) begin
                        stop_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            endcase
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            uart_q     <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            uart_q     <= uart_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: push is already blocked while reset_n is low.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four configurations (8N1, 8E1, 8O1, 7O2) checked
// every cycle against a queue-based bit-stream model of the line.
module tb_uart_tx_buffered;

    localparam longint INC = ((longint'(100_000) << 12) + (longint'(1_000_000) >> 5)) / (longint'(1_000_000) >> 4);
    localparam int DEPTH = 16;
    localparam int DB  [4] = '{8, 8, 8, 7};
    localparam int PAR [4] = '{0, 2, 1, 1};
    localparam int SB  [4] = '{1, 1, 1, 2};
    localparam logic [31:0] EXP_FRAME [4] = '{32'h14B, 32'h295, 32'h297, 32'h20F};

    logic       clock;
    logic       reset_n;
    logic [3:0] dv;
    logic [8:0] din    [4];
    logic [3:0] rdy;
    logic [3:0] line;
    logic [3:0] busy;
    logic [4:0] cnt    [4];
    logic [1:0] st_dbg [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            localparam int DBG = DB[g];
            uart_tx_buffered #(
                .freq_in(1_000_000), .freq_out(100_000), .acc_precision(16),
                .data_bits(DBG), .parity(PAR[g]), .stop_bits(SB[g]), .fifo_depth(DEPTH)
            ) u_dut (
                .clock(clock), .reset_n(reset_n), .data_in(din[g][DBG-1:0]),
                .data_valid(dv[g]), .data_ready(rdy[g]), .uart_out(line[g]),
                .busy(busy[g]), .fifo_count(cnt[g]), .state_dbg(st_dbg[g])
            );
        end
    endgenerate

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard and model state
    int         n_pass;
    int         n_checks;
    longint     m_cnt;
    logic [8:0] exp_q    [4][$];
    bit         stream_q [4][$];
    bit         rec_q    [4][$];
    bit         exp_line [4];
    bit         rec_en;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    // Baud tick as a carry of m*INC across a 2^16 boundary.
    function automatic bit carry(longint m);
        if (m < 1) return 1'b0;
        return ((m * INC) >> 16) != (((m - 1) * INC) >> 16);
    endfunction

    function automatic int frame_len(int i);
        return 1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i];
    endfunction

    function automatic bit all_idle();
        for (int i = 0; i < 4; i++)
            if (exp_q[i].size() != 0 || stream_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_frame(int i, logic [8:0] w);
        int ones;
        ones = $countones(w);
        stream_q[i].push_back(1'b0);
        for (int b = 0; b < DB[i]; b++) stream_q[i].push_back(w[b]);
        if (PAR[i] == 1) stream_q[i].push_back((ones % 2) == 0);
        if (PAR[i] == 2) stream_q[i].push_back((ones % 2) == 1);
        for (int s = 0; s < SB[i]; s++) stream_q[i].push_back(1'b1);
    endtask

    // reference model + per-cycle comparison
    always @(posedge clock) begin
        bit         act;
        bit         psh;
        logic [8:0] w;
        act = 1'b0;
        if (!reset_n) begin
            m_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                exp_q[i].delete();
                stream_q[i].delete();
                exp_line[i] = 1'b1;
            end
        end else begin
            act = carry(m_cnt);
            m_cnt++;
            for (int i = 0; i < 4; i++) begin
                psh = dv[i] && (exp_q[i].size() < DEPTH);
                if (act) begin
                    if (stream_q[i].size() == 0 && exp_q[i].size() != 0) begin
                        w = exp_q[i].pop_front();
                        build_frame(i, w);
                    end
                    if (stream_q[i].size() != 0) exp_line[i] = stream_q[i].pop_front();
                    else exp_line[i] = 1'b1;
                end
                if (psh) exp_q[i].push_back(din[i] & ((9'h1 << DB[i]) - 9'h1));
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("line%0d", i), 32'(line[i]), 32'(exp_line[i]));
            check($sformatf("count%0d", i), 32'(cnt[i]), 32'(exp_q[i].size()));
            check($sformatf("busy%0d", i), 32'(busy[i]),
                  32'(exp_q[i].size() != 0 || stream_q[i].size() != 0));
            check($sformatf("ready%0d", i), 32'(rdy[i]),
                  32'(reset_n && exp_q[i].size() < DEPTH));
            if (act && rec_en && (rec_q[i].size() != 0 || line[i] == 1'b0)
                && rec_q[i].size() < frame_len(i))
                rec_q[i].push_back(line[i]);
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic drive_push(int i, logic [8:0] w);
        dv[i]  = 1'b1;
        din[i] = w;
        @(negedge clock);
        dv[i]  = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int k;
        k = 0;
        while (!all_idle() && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (!all_idle()) check("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        bit          found;
        n_pass   = 0;
        n_checks = 0;
        m_cnt    = 0;
        rec_en   = 1'b0;
        reset_n  = 1'b0;
        dv       = '0;
        for (int i = 0; i < 4; i++) begin
            din[i]      = '0;
            exp_line[i] = 1'b1;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_line%0d", i), 32'(line[i]), 32'd1);
            check($sformatf("rst_count%0d", i), 32'(cnt[i]), 32'd0);
            check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd0);
            check($sformatf("rst_state%0d", i), 32'(st_dbg[i]), 32'd0);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // single frame per configuration, recorded tick by tick
        rec_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rec_q[i].delete();
            dv[i]  = 1'b1;
            din[i] = (i == 3) ? 9'h041 : 9'h0A5;
        end
        @(negedge clock);
        dv = '0;
        wait_idle(400);
        rec_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 0;
            for (int k = 0; k < rec_q[i].size(); k++) v = (v << 1) | 32'(rec_q[i][k]);
            check($sformatf("frame_len%0d", i), 32'(rec_q[i].size()), 32'(frame_len(i)));
            check($sformatf("frame_bits%0d", i), v, EXP_FRAME[i]);
        end

        // burst of 40 words into the 8N1 channel
        for (int k = 0; k < 40; k++) begin
            dv[0]  = 1'b1;
            din[0] = 9'(k);
            @(negedge clock);
        end
        dv[0] = 1'b0;
        wait_idle(5000);

        // two back-to-back words
        drive_push(0, 9'h0C3);
        drive_push(0, 9'h03C);
        wait_idle(600);

        // reset during data bit 3 with five words still queued
        for (int k = 0; k < 6; k++) drive_push(0, 9'(8'h10 + k));
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            if (stream_q[0].size() == 5 && exp_q[0].size() == 5) found = 1'b1;
            else @(negedge clock);
        end
        check("mid_frame_reached", 32'(found), 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("trunc_line", 32'(line[0]), 32'd1);
        check("trunc_count", 32'(cnt[0]), 32'd0);
        check("trunc_busy", 32'(busy[0]), 32'd0);
        repeat (200) @(negedge clock);

        // push coinciding with an IDLE pop at fifo_count = 1
        drive_push(0, 9'h05A);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (carry(m_cnt) && exp_q[0].size() == 1 && stream_q[0].size() == 0) begin
                found = 1'b1;
                drive_push(0, 9'h0E7);
                check("push_pop_count", 32'(cnt[0]), 32'd1);
            end else begin
                @(negedge clock);
            end
        end
        check("push_pop_found", 32'(found), 32'd1);
        wait_idle(600);

        // randomized traffic: heavy load first, then light
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                dv[i]  = ($urandom_range(0, (c < 2000) ? 3 : 40) == 0);
                din[i] = 9'($urandom_range(0, 511));
            end
            @(negedge clock);
        end
        dv = '0;
        wait_idle(4000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
